// File: rtl/cpu_pkg.sv
// Shared pipeline types and constants for the 5-stage core.
package cpu_pkg;

    // IF/ID pipeline register contents; also consumed by the decode stage.
    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
    } if_id_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Bubble: no instruction, zeroed payload.
    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc4: 32'h0000_0000};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: async reset, load enable, flush-to-bubble.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load_en,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_q;

    // Flush beats hold so a redirect during a stall still kills the wrong-path slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= IF_ID_BUBBLE;
        end else if (flush) begin
            q_q <= IF_ID_BUBBLE;
        end else if (load_en) begin
            q_q <= d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads imem, fills IF/ID,
// applies stall/redirect and flags illegal fetch addresses.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_WORDS = 256,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_instr,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      pc,
    output logic             if_id_valid,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [31:0]      IMEM_WORDS_W = 32'(IMEM_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_q, pc_d;
    logic             fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
    logic [31:0]      pc_plus4;
    logic             legal;
    logic             do_fetch;
    logic             flush;
    if_id_t           if_id_d, if_id_q;

    assign pc_plus4 = pc_q + 32'd4;

    // Full 32-bit word-index compare so out-of-range PCs never alias into imem.
    assign legal = (pc_q[1:0] == 2'b00) && ({2'b00, pc_q[31:2]} < IMEM_WORDS_W);

    // Next-state for PC, error flag and counter in redirect > stall > illegal > fetch order.
    always_comb begin
        pc_d          = pc_q;
        fetch_err_d   = fetch_err_q;
        fetch_count_d = fetch_count_q;
        do_fetch      = 1'b0;
        flush         = 1'b0;
        if (redirect_valid) begin
            pc_d  = redirect_pc;
            flush = 1'b1;
        end else if (stall) begin
            // hold everything
        end else if (!legal) begin
            fetch_err_d = 1'b1;
            flush       = 1'b1;
        end else begin
            pc_d          = pc_plus4;
            fetch_count_d = fetch_count_q + CNT_ONE;
            do_fetch      = 1'b1;
        end
    end

    // PC, sticky error and fetch counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            fetch_err_q   <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_err_q   <= fetch_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign if_id_d = '{valid: 1'b1, instr: imem_instr, pc4: pc_plus4};

    // load_en is only consulted when flush is low, i.e. on the stall and fetch paths.
    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_en (do_fetch),
        .flush   (flush),
        .d       (if_id_d),
        .q       (if_id_q)
    );

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign if_id_valid = if_id_q.valid;
    assign if_id_instr = if_id_q.instr;
    assign if_id_pc4   = if_id_q.pc4;
    assign fetch_err   = fetch_err_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit (CNT_W=4 to exercise wrap).
module tb_if_fetch_unit;

    localparam logic [31:0] LW_INSTR  = 32'h0002_A303;
    localparam logic [31:0] ADD_INSTR = 32'h0073_02B3;
    localparam logic [31:0] OOR_INSTR = 32'hBAD0_BAD0;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        fetch_err;
    logic [3:0]  fetch_count;

    logic [31:0] mem [256];

    int tests_run = 0;
    int tests_failed = 0;

    if_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (256),
        .CNT_W      (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc4      (if_id_pc4),
        .fetch_err      (fetch_err),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Combinational imem model.
    always_comb begin
        imem_instr = OOR_INSTR;
        if (imem_addr[31:10] == 22'd0) imem_instr = mem[imem_addr[9:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                             input logic [31:0] e_instr, input logic [31:0] e_pc4,
                             input int e_cnt, input logic e_err);
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".imem_addr"}, imem_addr, e_pc);
        check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
        check({tag, ".instr"}, if_id_instr, e_instr);
        check({tag, ".pc4"}, if_id_pc4, e_pc4);
        check({tag, ".count"}, {28'd0, fetch_count}, 32'(e_cnt % 16));
        check({tag, ".err"}, {31'd0, fetch_err}, {31'd0, e_err});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0]  = LW_INSTR;
        mem[1]  = ADD_INSTR;
        mem[11] = 32'h0000_0000; // nop must still count as valid

        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        #12;
        check_all("reset", 32'h0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        rst = 1'b0;

        // Free run
        step(); check_all("fetch0", 32'h4, 1'b1, LW_INSTR, 32'h4, 1, 1'b0);
        step(); check_all("fetch1", 32'h8, 1'b1, ADD_INSTR, 32'h8, 2, 1'b0);

        // One-cycle stall
        stall = 1'b1;
        step(); check_all("stall", 32'h8, 1'b1, ADD_INSTR, 32'h8, 2, 1'b0);
        stall = 1'b0;
        step(); check_all("resume", 32'hC, 1'b1, 32'h1000_0002, 32'hC, 3, 1'b0);

        // Redirect wins over stall
        redirect_valid = 1'b1; redirect_pc = 32'h2C; stall = 1'b1;
        step(); check_all("redir", 32'h2C, 1'b0, 32'h0, 32'h0, 3, 1'b0);
        redirect_valid = 1'b0; stall = 1'b0;
        step(); check_all("redir_tgt", 32'h30, 1'b1, 32'h0, 32'h30, 4, 1'b0);

        // Misaligned target
        redirect_valid = 1'b1; redirect_pc = 32'h402;
        step(); check_all("mis_redir", 32'h402, 1'b0, 32'h0, 32'h0, 4, 1'b0);
        redirect_valid = 1'b0;
        step(); check_all("mis_hold", 32'h402, 1'b0, 32'h0, 32'h0, 4, 1'b1);

        // Out-of-range target
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        step(); check_all("oor_redir", 32'h400, 1'b0, 32'h0, 32'h0, 4, 1'b1);
        redirect_valid = 1'b0;
        step(); check_all("oor_hold", 32'h400, 1'b0, 32'h0, 32'h0, 4, 1'b1);

        // Word index 0x401 aliases index 1 in its low 8 bits but is illegal
        redirect_valid = 1'b1; redirect_pc = 32'h1004;
        step();
        redirect_valid = 1'b0;
        step(); check_all("alias_hold", 32'h1004, 1'b0, 32'h0, 32'h0, 4, 1'b1);

        // Recovery keeps sticky error
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step(); check_all("recover", 32'h0, 1'b0, 32'h0, 32'h0, 4, 1'b1);
        redirect_valid = 1'b0;
        step(); check_all("recover_f", 32'h4, 1'b1, LW_INSTR, 32'h4, 5, 1'b1);

        // Run to pc=0x20 then assert reset between edges
        for (int i = 0; i < 7; i++) step();
        check_all("pre_rst", 32'h20, 1'b1, 32'h1000_0007, 32'h20, 12, 1'b1);
        #2 rst = 1'b1;
        #1 check_all("async_rst", 32'h0, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        #2 rst = 1'b0;

        // Counter wrap at 2^4
        for (int i = 0; i < 15; i++) step();
        check_all("cnt15", 32'h3C, 1'b1, 32'h1000_000E, 32'h3C, 15, 1'b0);
        step();
        check_all("cnt_wrap", 32'h40, 1'b1, 32'h1000_000F, 32'h40, 0, 1'b0);

        // Top-of-space target: illegal, PC must not wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step(); check_all("top_redir", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 0, 1'b0);
        redirect_valid = 1'b0;
        step(); check_all("top_hold", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 0, 1'b1);
        step(); check_all("top_hold2", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
